// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 keyboard receiver:
//               framing state encoding, scan-code prefix bytes and the
//               FIFO entry layout used when break/extended decoding is on.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Framing states, explicitly encoded on 2 bits
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // Prefix bytes announcing an extended key and a key release
  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;

  // Decoded FIFO entry: ext in the MSB, then brk, then the scan code
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_entry_t;

  // Odd parity: data bits plus parity bit must hold an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_sync_fifo
// Description : Generic single-clock show-ahead FIFO. The head entry is
//               always visible on rd_data; a read while empty is ignored and
//               a write while full is accepted only if a read frees a slot in
//               the same cycle. DEPTH must be a power of two (>= 2).
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int                  c_PTR_W     = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]    c_DEPTH_CNT = (c_PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_do_rd;
  logic               w_do_wr;

  assign empty   = (r_count == '0);
  assign full    = (r_count == c_DEPTH_CNT);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  // A pop frees the slot a simultaneous push needs, so full+push+pop succeeds
  assign w_do_rd = rd_en & ~empty;
  assign w_do_wr = wr_en & (~full | w_do_rd);

  // Storage array; cleared on reset so the head reads zero afterwards
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy tracking
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo
// Description : PS/2 keyboard receiver. Synchronises and glitch-filters the
//               keyboard clock, frames 11-bit packets (start, 8 data LSB
//               first, odd parity, stop), aborts stalled frames by timeout
//               and buffers accepted scan codes in a show-ahead FIFO read
//               over a valid/ready handshake.
//               Optional macro PS2_BREAK_DECODE_EN: E0/F0 prefixes are folded
//               into ext/brk flags of the following scan code entry.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    key_code,
  output logic                          key_ext,
  output logic                          key_brk,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int                 c_FILT_W   = $clog2(FILTER_LEN);
  localparam logic [c_FILT_W-1:0] c_FILT_MAX = c_FILT_W'(FILTER_LEN - 1);
  localparam int                 c_TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TO_W-1:0]  c_TO_MAX   = c_TO_W'(TIMEOUT_CYCLES - 1);

  logic                r_clk_s1, r_clk_s2;
  logic                r_dat_s1, r_dat_s2;
  logic                r_filt;
  logic [c_FILT_W-1:0] r_fcnt;
  logic                w_fall;

  rx_state_t           r_state;
  logic [2:0]          r_bitcnt;
  logic [7:0]          r_shift;
  logic                r_parity_ok;
  logic [c_TO_W-1:0]   r_tocnt;
  logic                r_frame_err;
  logic                r_parity_err;
  logic                r_accept;
  logic                r_overflow;

  logic                w_push;
  logic                w_full;
  logic                w_empty;

  // Two-flop synchronisers; idle bus level is high
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Glitch filter: level follows the input only after FILTER_LEN opposite samples
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_filt <= 1'b1;
      r_fcnt <= '0;
    end else if (r_clk_s2 == r_filt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == c_FILT_MAX) begin
      r_filt <= r_clk_s2;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end

  // Strobe in the cycle the filtered clock is about to drop
  assign w_fall = r_filt & ~r_clk_s2 & (r_fcnt == c_FILT_MAX);

  // Framing state machine with stall timeout; outcome flags are registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_parity_ok  <= 1'b0;
      r_tocnt      <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_accept     <= 1'b0;
    end else begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_accept     <= 1'b0;

      if (r_state == IDLE || w_fall) r_tocnt <= '0;
      else                           r_tocnt <= r_tocnt + 1'b1;

      case (r_state)
        IDLE: begin
          // A high "start" bit is line noise, not a frame
          if (w_fall && !r_dat_s2) begin
            r_state  <= DATA;
            r_bitcnt <= '0;
          end
        end
        DATA: begin
          if (w_fall) begin
            r_shift  <= {r_dat_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7) r_state <= PARITY;
          end
        end
        PARITY: begin
          if (w_fall) begin
            r_parity_ok <= odd_parity_ok(r_shift, r_dat_s2);
            r_state     <= STOP;
          end
        end
        STOP: begin
          if (w_fall) begin
            r_state <= IDLE;
            // A bad stop bit hides any parity problem
            if (!r_dat_s2)         r_frame_err  <= 1'b1;
            else if (!r_parity_ok) r_parity_err <= 1'b1;
            else                   r_accept     <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (r_state != IDLE && !w_fall && r_tocnt == c_TO_MAX) begin
        r_state     <= IDLE;
        r_frame_err <= 1'b1;
      end
    end
  end

  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;

`ifdef PS2_BREAK_DECODE_EN
  logic       r_ext_pend;
  logic       r_brk_pend;
  logic       w_is_prefix;
  key_entry_t w_wr_entry;
  key_entry_t w_rd_entry;

  assign w_is_prefix = (r_shift == PS2_EXT_CODE) || (r_shift == PS2_BRK_CODE);
  assign w_push      = r_accept & ~w_is_prefix;
  assign w_wr_entry  = {r_ext_pend, r_brk_pend, r_shift};

  // Pending prefix flags: set by E0/F0, consumed by the next real code, lost on error
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (r_frame_err || r_parity_err) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (r_accept) begin
      if (r_shift == PS2_EXT_CODE) begin
        r_ext_pend <= 1'b1;
      end else if (r_shift == PS2_BRK_CODE) begin
        r_brk_pend <= 1'b1;
      end else begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end
    end
  end

  ps2_sync_fifo #(
    .WIDTH ($bits(key_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_push),
    .wr_data (w_wr_entry),
    .rd_en   (key_ready),
    .rd_data (w_rd_entry),
    .count   (fifo_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign key_code = w_rd_entry.code;
  assign key_ext  = w_rd_entry.ext;
  assign key_brk  = w_rd_entry.brk;
`else
  assign w_push = r_accept;

  ps2_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_push),
    .wr_data (r_shift),
    .rd_en   (key_ready),
    .rd_data (key_code),
    .count   (fifo_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign key_ext = 1'b0;
  assign key_brk = 1'b0;
`endif

  assign key_valid = ~w_empty;

  // Flag a good byte that found the FIFO full with no pop to make room
  always_ff @(posedge clk) begin
    if (!rst) r_overflow <= 1'b0;
    else      r_overflow <= w_push & w_full & ~key_ready;
  end

  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx_fifo
// Description : Directed self-checking bench for ps2_rx_fifo. The keyboard
//               is modelled with a short bit period and a shortened timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_fifo;

  localparam int FILTER_LEN     = 8;
  localparam int FIFO_DEPTH     = 8;
  localparam int TIMEOUT_CYCLES = 600;
  localparam int HALF           = 40;   // clk cycles per PS/2 clock phase
  localparam int GAP            = 30;   // idle cycles after each frame

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       ps2_clk   = 1'b1;
  logic       ps2_data  = 1'b1;
  logic       key_ready = 1'b0;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_brk;
  logic       key_valid;
  logic [3:0] fifo_count;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int n_par  = 0;
  int n_frm  = 0;
  int n_ovf  = 0;

  ps2_rx_fifo #(
    .FILTER_LEN     (FILTER_LEN),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_brk    (key_brk),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .fifo_count (fifo_count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Running totals of every error pulse seen
  always @(negedge clk) begin
    if (parity_err) n_par = n_par + 1;
    if (frame_err)  n_frm = n_frm + 1;
    if (overflow)   n_ovf = n_ovf + 1;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One PS/2 bit: data set up, clock low for HALF, clock high for HALF.
  // Optional low glitch in the high phase; optional 1-cycle pop aligned to
  // the FIFO write that this falling edge produces.
  task automatic ps2_bit(input logic v, input int glitch_len, input logic pop_here);
    @(negedge clk);
    ps2_data = v;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    if (pop_here) begin
      repeat (10) @(negedge clk);
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      repeat (HALF - 11) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b1;
    if (glitch_len > 0) begin
      repeat (15) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (glitch_len) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (15) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit,
                            input logic glitch, input logic pop_at_stop);
    logic [10:0] f;
    f = {stop_bit, ~(^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < 11; i++)
      ps2_bit(f[i], (glitch && i == 3) ? 1 : ((glitch && i == 6) ? FILTER_LEN - 1 : 0),
              pop_at_stop && i == 10);
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [10:0] f;
    f = {1'b1, ~(^b), b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], 0, 1'b0);
    ps2_data = 1'b1;
  endtask

  task automatic drain();
    key_ready = 1'b1;
    for (int i = 0; i < 20 && key_valid; i++) @(negedge clk);
    key_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key_ready = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", key_valid); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    checks++; if (key_code !== 8'h00) begin errors++; $display("FAIL reset_code got %h want 00", key_code); end
    checks++; if ({key_ext, key_brk} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {key_ext, key_brk}); end
    checks++; if ({parity_err, frame_err, overflow} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {parity_err, frame_err, overflow}); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL ready_while_empty got %0d want 0", fifo_count); end
    key_ready = 1'b0;
  endtask

  task automatic test_good_frame();
    int p0, f0;
    p0 = n_par; f0 = n_frm;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL good_valid got %b want 1", key_valid); end
    checks++; if (key_code !== 8'h1C) begin errors++; $display("FAIL good_code got %h want 1c", key_code); end
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL good_count got %0d want 1", fifo_count); end
    checks++; if ({key_ext, key_brk} !== 2'b00) begin errors++; $display("FAIL good_flags got %b want 00", {key_ext, key_brk}); end
    checks++; if (n_par - p0 != 0 || n_frm - f0 != 0) begin errors++; $display("FAIL good_no_err got par=%0d frm=%0d want 0 0", n_par - p0, n_frm - f0); end
    drain();
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL good_drained got %0d want 0", fifo_count); end
  endtask

  task automatic test_errors();
    int p0, f0;
    p0 = n_par; f0 = n_frm;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (n_par - p0 != 1 || n_frm - f0 != 0) begin errors++; $display("FAIL parity_pulse got par=%0d frm=%0d want 1 0", n_par - p0, n_frm - f0); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL parity_drop got %0d want 0", fifo_count); end
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (n_par - p0 != 1 || n_frm - f0 != 1) begin errors++; $display("FAIL stop_precedence got par=%0d frm=%0d want 1 1", n_par - p0, n_frm - f0); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL stop_drop got %0d want 0", fifo_count); end
  endtask

  task automatic test_timeout();
    int p0, f0;
    p0 = n_par; f0 = n_frm;
    send_partial(8'h29, 3);
    repeat (TIMEOUT_CYCLES + 100) @(negedge clk);
    checks++; if (n_frm - f0 != 1 || n_par - p0 != 0) begin errors++; $display("FAIL timeout_pulse got frm=%0d par=%0d want 1 0", n_frm - f0, n_par - p0); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL timeout_drop got %0d want 0", fifo_count); end
    send_frame(8'h29, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (key_code !== 8'h29 || fifo_count !== 4'd1) begin errors++; $display("FAIL after_timeout got %h/%0d want 29/1", key_code, fifo_count); end
    checks++; if (n_frm - f0 != 1) begin errors++; $display("FAIL after_timeout_err got %0d want 1", n_frm - f0); end
    drain();
  endtask

  task automatic test_glitch();
    int p0, f0;
    p0 = n_par; f0 = n_frm;
    @(negedge clk);
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    @(negedge clk);
    ps2_clk  = 1'b1;
    repeat (20) @(negedge clk);
    ps2_clk  = 1'b0;
    repeat (FILTER_LEN - 1) @(negedge clk);
    ps2_clk  = 1'b1;
    repeat (20) @(negedge clk);
    ps2_data = 1'b1;
    repeat (TIMEOUT_CYCLES + 100) @(negedge clk);
    checks++; if (n_frm - f0 != 0 || key_valid !== 1'b0) begin errors++; $display("FAIL idle_glitch got frm=%0d valid=%b want 0 0", n_frm - f0, key_valid); end
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (key_code !== 8'h5A || fifo_count !== 4'd1) begin errors++; $display("FAIL frame_glitch got %h/%0d want 5a/1", key_code, fifo_count); end
    checks++; if (n_frm - f0 != 0 || n_par - p0 != 0) begin errors++; $display("FAIL glitch_err got frm=%0d par=%0d want 0 0", n_frm - f0, n_par - p0); end
    drain();
  endtask

  task automatic test_overflow();
    int o0;
    logic [7:0] e;
    o0 = n_ovf;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (n_ovf - o0 != 1) begin errors++; $display("FAIL overflow_pulse got %0d want 1", n_ovf - o0); end
    checks++; if (fifo_count !== 4'd8 || key_code !== 8'h01) begin errors++; $display("FAIL overflow_state got %0d/%h want 8/01", fifo_count, key_code); end
    send_frame(8'h0A, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++; if (fifo_count !== 4'd8 || n_ovf - o0 != 1) begin errors++; $display("FAIL push_pop_full got cnt=%0d ovf=%0d want 8 1", fifo_count, n_ovf - o0); end
    key_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = (i < 7) ? 8'(i + 2) : 8'h0A;
      checks++; if (key_valid !== 1'b1 || key_code !== e) begin errors++; $display("FAIL drain_order[%0d] got %b/%h want 1/%h", i, key_valid, key_code, e); end
      @(negedge clk);
    end
    key_ready = 1'b0;
    checks++; if (key_valid !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL drain_empty got %b/%0d want 0/0", key_valid, fifo_count); end
  endtask

  task automatic test_prefix();
    int p0;
    p0 = n_par;
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef PS2_BREAK_DECODE_EN
    checks++; if (fifo_count !== 4'd1 || {key_ext, key_brk, key_code} !== {2'b11, 8'h75}) begin errors++; $display("FAIL prefix_both got %0d/%b%b/%h want 1/11/75", fifo_count, key_ext, key_brk, key_code); end
    drain();
`else
    begin
      logic [7:0] exp3 [3];
      exp3 = '{8'hE0, 8'hF0, 8'h75};
      checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL raw_count got %0d want 3", fifo_count); end
      key_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        checks++; if ({key_ext, key_brk, key_code} !== {2'b00, exp3[i]}) begin errors++; $display("FAIL raw_entry[%0d] got %b%b/%h want 00/%h", i, key_ext, key_brk, key_code, exp3[i]); end
        @(negedge clk);
      end
      key_ready = 1'b0;
    end
`endif
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h12, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (n_par - p0 != 1) begin errors++; $display("FAIL prefix_parity got %0d want 1", n_par - p0); end
`ifdef PS2_BREAK_DECODE_EN
    checks++; if (fifo_count !== 4'd1 || {key_ext, key_brk, key_code} !== {2'b00, 8'h1C}) begin errors++; $display("FAIL prefix_cleared got %0d/%b%b/%h want 1/00/1c", fifo_count, key_ext, key_brk, key_code); end
`else
    checks++; if (fifo_count !== 4'd2 || key_code !== 8'hF0) begin errors++; $display("FAIL raw_f0 got %0d/%h want 2/f0", fifo_count, key_code); end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    checks++; if (key_code !== 8'h1C || key_ext !== 1'b0) begin errors++; $display("FAIL raw_1c got %h/%b want 1c/0", key_code, key_ext); end
`endif
    drain();
  endtask

  task automatic test_mid_reset();
    int f0;
    send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (fifo_count !== 4'd1 || key_code !== 8'h33) begin errors++; $display("FAIL pre_reset got %0d/%h want 1/33", fifo_count, key_code); end
    send_partial(8'h66, 5);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    f0 = n_frm;
    checks++; if (key_valid !== 1'b0 || fifo_count !== 4'd0 || key_code !== 8'h00) begin errors++; $display("FAIL mid_reset got %b/%0d/%h want 0/0/00", key_valid, fifo_count, key_code); end
    repeat (TIMEOUT_CYCLES + 100) @(negedge clk);
    checks++; if (n_frm - f0 != 0) begin errors++; $display("FAIL mid_reset_err got %0d want 0", n_frm - f0); end
    send_frame(8'h4B, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (fifo_count !== 4'd1 || key_code !== 8'h4B) begin errors++; $display("FAIL post_reset got %0d/%h want 1/4b", fifo_count, key_code); end
    drain();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_errors();
    test_timeout();
    test_glitch();
    test_overflow();
    test_prefix();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
